day_night_ctrl: RTL and testbench

Upstream game-state block that owns the day/night cycle. It counts frames while the game runs, steps through DAY → DUSK → NIGHT → DAWN, and produces three things:
- `isnight` and a one-cycle `night_start` pulse, consumed by the moon/star sprite stage; `night_start` is the moment a new moon phase is chosen.
- A 4-bit `fade_level`, consumed by the palette/colour-mapping stage.
- A saturating night counter, for difficulty/score logic.

---
 rtl/daynight_pkg.sv | 27 ++
 rtl/day_night_ctrl.sv | 170 +++++++++++++++++
 tb/tb_day_night_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/daynight_pkg.sv
// Shared types and constants for the day/night cycle controller.
package daynight_pkg;

    // Phase encoding is externally visible: DAY=0, DUSK=1, NIGHT=2, DAWN=3.
    typedef enum logic [1:0] {
        DAY   = 2'd0,
        DUSK  = 2'd1,
        NIGHT = 2'd2,
        DAWN  = 2'd3
    } phase_t;

    localparam logic [3:0] FADE_MAX        = 4'd15;
    localparam logic [7:0] NIGHT_COUNT_MAX = 8'd255;

    // Frame counter width: enough bits for the longest phase/step, at least 1.
    function automatic int cnt_width(input int day_frames, input int night_frames,
                                     input int step_frames);
        int longest;
        int w;
        longest = day_frames;
        if (night_frames > longest) longest = night_frames;
        if (step_frames > longest) longest = step_frames;
        w = $clog2(longest);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/day_night_ctrl.sv
// Day/night cycle controller: counts frames while the game runs and steps
// DAY -> DUSK -> NIGHT -> DAWN, producing the phase, a palette fade level,
// a NIGHT-entry pulse and a saturating night counter.
// Optional debug override enabled by defining DAYNIGHT_FORCE_EN, which adds
// the force_night input.
module day_night_ctrl
    import daynight_pkg::*;
#(
    parameter int DAY_FRAMES   = 1200,
    parameter int NIGHT_FRAMES = 600,
    parameter int STEP_FRAMES  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       game_run,
`ifdef DAYNIGHT_FORCE_EN
    input  logic       force_night,
`endif
    output logic       isnight,
    output logic       night_start,
    output logic [3:0] fade_level,
    output logic [1:0] phase,
    output logic [7:0] night_count
);

    localparam int CNT_W = cnt_width(DAY_FRAMES, NIGHT_FRAMES, STEP_FRAMES);

    localparam logic [CNT_W-1:0] DAY_LAST   = CNT_W'(DAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] NIGHT_LAST = CNT_W'(NIGHT_FRAMES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    phase_t           phase_q,       phase_d;
    logic [CNT_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic [3:0]       fade_q,        fade_d;
    logic [7:0]       night_count_q, night_count_d;
    logic             night_start_q, night_start_d;
    logic             isnight_q,     isnight_d;

    // Result of one counted tick, before any override is applied.
    phase_t           adv_phase;
    logic [CNT_W-1:0] adv_cnt;
    logic [3:0]       adv_fade;

    logic counted_tick;

`ifdef DAYNIGHT_FORCE_EN
    logic force_q, force_d;
`endif

    // A frame only counts while the game is running.
    assign counted_tick = frame_tick & game_run;

    // Advance the cycle by one counted tick.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        adv_phase = phase_q;
        adv_cnt   = frame_cnt_q;
        adv_fade  = fade_q;
        if (counted_tick) begin
            unique case (phase_q)
                DAY: begin
                    if (frame_cnt_q == DAY_LAST) begin
                        adv_phase = DUSK;
                        adv_cnt   = '0;
                        adv_fade  = 4'd0;
                    end else begin
                        adv_cnt = frame_cnt_q + CNT_ONE;
                    end
                end
                DUSK: begin
                    if (frame_cnt_q == STEP_LAST) begin
                        adv_cnt  = '0;
                        adv_fade = fade_q + 4'd1;
                        // The step that reaches full night ends DUSK.
                        if (fade_q == FADE_MAX - 4'd1) adv_phase = NIGHT;
                    end else begin
                        adv_cnt = frame_cnt_q + CNT_ONE;
                    end
                end
                NIGHT: begin
                    adv_fade = FADE_MAX;
                    if (frame_cnt_q == NIGHT_LAST) begin
                        adv_phase = DAWN;
                        adv_cnt   = '0;
                    end else begin
                        adv_cnt = frame_cnt_q + CNT_ONE;
                    end
                end
                DAWN: begin
                    if (frame_cnt_q == STEP_LAST) begin
                        adv_cnt  = '0;
                        adv_fade = fade_q - 4'd1;
                        // The step that reaches full day ends DAWN.
                        if (fade_q == 4'd1) adv_phase = DAY;
                    end else begin
                        adv_cnt = frame_cnt_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Apply the debug override, then derive NIGHT-entry side effects.
    always_comb begin
        phase_d       = adv_phase;
        frame_cnt_d   = adv_cnt;
        fade_d        = adv_fade;
        night_count_d = night_count_q;
        night_start_d = 1'b0;

`ifdef DAYNIGHT_FORCE_EN
        force_d = force_night;
        if (force_night) begin
            // Override wins over any counted tick in the same cycle.
            phase_d     = NIGHT;
            fade_d      = FADE_MAX;
            frame_cnt_d = '0;
        end else if (force_q) begin
            // Release of the override starts a fresh DAWN.
            phase_d     = DAWN;
            fade_d      = FADE_MAX;
            frame_cnt_d = '0;
        end
`endif

        // Only a transition into NIGHT pulses, so holding NIGHT never repeats it.
        if (phase_d == NIGHT && phase_q != NIGHT) begin
            night_start_d = 1'b1;
            if (night_count_q != NIGHT_COUNT_MAX) night_count_d = night_count_q + 8'd1;
        end

        isnight_d = (phase_d == NIGHT);
    end

    // State register for the FSM, counters and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: clocked state uses non-blocking assignments only.
        if (Reset) begin
            phase_q       <= DAY;
            frame_cnt_q   <= '0;
            fade_q        <= 4'd0;
            night_count_q <= 8'd0;
            night_start_q <= 1'b0;
            isnight_q     <= 1'b0;
`ifdef DAYNIGHT_FORCE_EN
            force_q       <= 1'b0;
`endif
        end else begin
            phase_q       <= phase_d;
            frame_cnt_q   <= frame_cnt_d;
            fade_q        <= fade_d;
            night_count_q <= night_count_d;
            night_start_q <= night_start_d;
            isnight_q     <= isnight_d;
`ifdef DAYNIGHT_FORCE_EN
            force_q       <= force_d;
`endif
        end
    end

    assign phase       = phase_q;
    assign fade_level  = fade_q;
    assign isnight     = isnight_q;
    assign night_start = night_start_q;
    assign night_count = night_count_q;

endmodule

// File: tb/tb_day_night_ctrl.sv
// Self-checking bench for day_night_ctrl (DAY=4, NIGHT=3, STEP=2 frames).
// The reference model tracks the position within one full cycle of counted
// ticks and derives phase and fade level from it arithmetically.
// Force scenarios are exercised when DAYNIGHT_FORCE_EN is defined.
module tb_day_night_ctrl;

    localparam int DF        = 4;
    localparam int NF        = 3;
    localparam int SF        = 2;
    localparam int NIGHT_POS = DF + 15 * SF;     // first tick position of NIGHT
    localparam int DAWN_POS  = NIGHT_POS + NF;   // first tick position of DAWN
    localparam int CYCLE_LEN = DAWN_POS + 15 * SF;

    logic       Clk;
    logic       Reset;
    logic       frame_tick;
    logic       game_run;
    logic       force_night;
    logic       isnight;
    logic       night_start;
    logic [3:0] fade_level;
    logic [1:0] phase;
    logic [7:0] night_count;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model state.
    int m_pos;
    int m_count;
    bit m_ns;
    bit m_fq;

    day_night_ctrl #(
        .DAY_FRAMES  (DF),
        .NIGHT_FRAMES(NF),
        .STEP_FRAMES (SF)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .game_run   (game_run),
`ifdef DAYNIGHT_FORCE_EN
        .force_night(force_night),
`endif
        .isnight    (isnight),
        .night_start(night_start),
        .fade_level (fade_level),
        .phase      (phase),
        .night_count(night_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int phase_of(input int p);
        if (p < DF) return 0;
        if (p < NIGHT_POS) return 1;
        if (p < DAWN_POS) return 2;
        return 3;
    endfunction

    function automatic int fade_of(input int p);
        if (p < DF) return 0;
        if (p < NIGHT_POS) return (p - DF) / SF;
        if (p < DAWN_POS) return 15;
        return 15 - (p - DAWN_POS) / SF;
    endfunction

    function automatic int next_pos(input int p, input bit t, input bit r,
                                    input bit f, input bit fq);
        if (f) return NIGHT_POS;
        if (fq) return DAWN_POS;
        if (t && r) return (p + 1) % CYCLE_LEN;
        return p;
    endfunction

    function automatic bit enters_night(input int p, input int np);
        return (phase_of(np) == 2) && (phase_of(p) != 2);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model update.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_pos   <= 0;
            m_count <= 0;
            m_ns    <= 1'b0;
            m_fq    <= 1'b0;
        end else begin
            m_pos <= next_pos(m_pos, frame_tick, game_run, force_night, m_fq);
            m_ns  <= enters_night(m_pos, next_pos(m_pos, frame_tick, game_run, force_night, m_fq));
            if (enters_night(m_pos, next_pos(m_pos, frame_tick, game_run, force_night, m_fq))
                && m_count < 255)
                m_count <= m_count + 1;
            m_fq <= force_night;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge Clk) begin
        if (cmp_en && !Reset) begin
            check("phase",       int'(phase),       phase_of(m_pos));
            check("fade_level",  int'(fade_level),  fade_of(m_pos));
            check("isnight",     int'(isnight),     (phase_of(m_pos) == 2) ? 1 : 0);
            check("night_start", int'(night_start), int'(m_ns));
            check("night_count", int'(night_count), m_count);
        end
    end

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic step(input logic t, input logic r);
        frame_tick = t;
        game_run   = r;
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        frame_tick = 1'b0;
        game_run   = 1'b0;
        force_night = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        int pulses;
        Reset       = 1'b1;
        frame_tick  = 1'b0;
        game_run    = 1'b0;
        force_night = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_phase",       int'(phase),       0);
        check("rst_fade",        int'(fade_level),  0);
        check("rst_isnight",     int'(isnight),     0);
        check("rst_night_start", int'(night_start), 0);
        check("rst_night_count", int'(night_count), 0);
        Reset  = 1'b0;
        cmp_en = 1'b1;

        // DAY -> DUSK -> NIGHT.
        ticks(4);
        check("dusk_entry_phase", int'(phase), 1);
        check("dusk_entry_fade",  int'(fade_level), 0);
        ticks(2);
        check("dusk_step1_fade", int'(fade_level), 1);
        ticks(28);
        check("night_phase",       int'(phase), 2);
        check("night_isnight",     int'(isnight), 1);
        check("night_start_pulse", int'(night_start), 1);
        check("night_count_1",     int'(night_count), 1);
        check("night_fade",        int'(fade_level), 15);
        step(1'b0, 1'b1);
        check("night_start_drop", int'(night_start), 0);

        // NIGHT -> DAWN -> DAY, one fade step every 2 ticks.
        ticks(3);
        check("dawn_phase", int'(phase), 3);
        check("dawn_fade",  int'(fade_level), 15);
        for (int k = 1; k <= 14; k++) begin
            ticks(2);
            check("dawn_fade_step", int'(fade_level), 15 - k);
        end
        ticks(2);
        check("day_again_phase",   int'(phase), 0);
        check("day_again_fade",    int'(fade_level), 0);
        check("day_again_isnight", int'(isnight), 0);

        // game_run low freezes DUSK mid-step.
        ticks(4 + 10 + 1);
        check("freeze_pre_phase", int'(phase), 1);
        check("freeze_pre_fade",  int'(fade_level), 5);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        check("freeze_phase", int'(phase), 1);
        check("freeze_fade",  int'(fade_level), 5);
        ticks(1);
        check("freeze_cnt_kept", int'(fade_level), 6);

        // Asynchronous reset while night_start is high.
        ticks(17);
        check("pre_rst_fade", int'(fade_level), 14);
        ticks(1);
        check("pre_rst_pulse", int'(night_start), 1);
        check("pre_rst_count", int'(night_count), 2);
        Reset = 1'b1;
        #1;
        check("async_rst_phase",   int'(phase), 0);
        check("async_rst_fade",    int'(fade_level), 0);
        check("async_rst_isnight", int'(isnight), 0);
        check("async_rst_pulse",   int'(night_start), 0);
        check("async_rst_count",   int'(night_count), 0);
        Reset = 1'b0;
        step(1'b0, 1'b1);
        ticks(3);
        check("post_rst_phase", int'(phase), 0);
        check("post_rst_fade",  int'(fade_level), 0);
        ticks(1);
        check("post_rst_dusk", int'(phase), 1);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
`ifdef DAYNIGHT_FORCE_EN
            force_night = ($urandom_range(0, 99) < 3) ? 1'b1 : (force_night && $urandom_range(0, 3) != 0);
`endif
            step(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        force_night = 1'b0;
        step(1'b0, 1'b0);

`ifdef DAYNIGHT_FORCE_EN
        // Force override from DAY.
        do_reset();
        step(1'b0, 1'b1);
        force_night = 1'b1;
        step(1'b0, 1'b0);
        check("force_phase", int'(phase), 2);
        check("force_fade",  int'(fade_level), 15);
        check("force_pulse", int'(night_start), 1);
        check("force_count", int'(night_count), 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            if (night_start) pulses++;
        end
        check("force_hold_pulses", pulses, 0);
        check("force_hold_phase", int'(phase), 2);
        force_night = 1'b0;
        step(1'b0, 1'b1);
        check("force_release_phase", int'(phase), 3);
        check("force_release_fade",  int'(fade_level), 15);
`endif

        // 260 full cycles: night_count saturates, pulses continue.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 260 * CYCLE_LEN; i++) begin
            step(1'b1, 1'b1);
            if (night_start) pulses++;
        end
        check("sat_pulses", pulses, 260);
        check("sat_count",  int'(night_count), 255);
        check("sat_phase",  int'(phase), 0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
